// File: rtl/unit_sqr_if.sv
// Handshake bundle for the squarer: f in on the request side, e/ovf out on the result side.
// Latency and backpressure are set by the attached unit_sqr instance.
// master drives requests and result-ready; slave is the squarer itself.
interface unit_sqr_if #(
    parameter int FW = 17,
    parameter int EW = 31
);
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] f;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] e;
    logic          ovf;

    modport master (
        output in_valid, f, out_ready,
        input  in_ready, out_valid, e, ovf
    );

    modport slave (
        input  in_valid, f, out_ready,
        output in_ready, out_valid, e, ovf
    );
endinterface

// File: rtl/unit_sqr.sv
// Iterative shift-add squarer: UQ4.13 f -> UQ7.24 e = f^2, saturating with ovf when f^2 >= 128.
// Latency: accept edge + 17 CALC edges, result held in DONE; one result per 19 cycles at best.
// Backpressure: DONE holds e/ovf until out_ready; in_ready is high only in IDLE.
module unit_sqr #(
    parameter int FW  = 17,
    parameter int EW  = 31,
    parameter int SHR = 2
) (
    input  logic        clk,
    input  logic        rst,
    unit_sqr_if.slave   sq_if
);
    localparam int AW = 2 * FW;
    localparam int CW = $clog2(FW);
    localparam logic [CW-1:0] LAST = CW'(FW - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic [FW-1:0] mcand;
    logic [FW-1:0] mplier;
    logic [AW-1:0] acc;
    logic [AW-1:0] addend;
    logic [AW-1:0] acc_nxt;
    logic [EW-1:0] e_q;
    logic          ovf_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sq_if.in_valid)     state_nxt = CALC;
            CALC:    if (count == LAST)      state_nxt = DONE;
            DONE:    if (sq_if.out_ready)    state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addend  = '0;
        if (mplier[count])
            addend = {{FW{1'b0}}, mcand} << count;
        acc_nxt = acc + addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            e_q    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (sq_if.in_valid) begin
                        mcand  <= sq_if.f;
                        mplier <= sq_if.f;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    count <= count + 1'b1;
                    // Result is registered off the final partial sum so it is ready on DONE entry.
                    if (count == LAST) begin
                        ovf_q <= acc_nxt[AW-1];
                        e_q   <= acc_nxt[AW-1] ? {EW{1'b1}} : acc_nxt[EW+SHR-1:SHR];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sq_if.in_ready  = (state == IDLE);
    assign sq_if.out_valid = (state == DONE);
    assign sq_if.e         = e_q;
    assign sq_if.ovf       = ovf_q;
endmodule

// File: tb/tb_unit_sqr.sv
// Directed bench for unit_sqr: hand-computed squares, truncation/saturation, backpressure,
// mid-operation reset and back-to-back throughput.
module tb_unit_sqr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    unit_sqr_if #(.FW(17), .EW(31)) sif ();

    unit_sqr #(.FW(17), .EW(31), .SHR(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .sq_if (sif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept f, scramble the input during CALC, wait for the result and complete the handshake.
    task automatic run_op(input string tag, input logic [16:0] fv,
                          input logic [30:0] exp_e, input logic exp_ovf);
        int n;
        sif.f         = fv;
        sif.in_valid  = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        sif.f        = 17'($urandom);
        check({tag, "_busy"}, 64'(sif.in_ready), 64'd0);
        n = 0;
        while (!sif.out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd17);
        check({tag, "_e"}, 64'(sif.e), 64'(exp_e));
        check({tag, "_ovf"}, 64'(sif.ovf), 64'(exp_ovf));
        tick();
        check({tag, "_idle"}, 64'({sif.in_ready, sif.out_valid}), 64'b10);
    endtask

    initial begin
        int n;
        int t_first;
        int t_second;
        logic [30:0] e_first;
        logic [30:0] e_second;

        sif.in_valid  = 1'b0;
        sif.f         = '0;
        sif.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(sif.in_ready), 64'd1);
        check("rst_out_valid", 64'(sif.out_valid), 64'd0);
        check("rst_e", 64'(sif.e), 64'd0);
        check("rst_ovf", 64'(sif.ovf), 64'd0);

        run_op("one",   17'h02000, 31'h01000000, 1'b0);
        run_op("eleven", 17'h16000, 31'h79000000, 1'b0);
        run_op("two",   17'h04000, 31'h04000000, 1'b0);
        run_op("max",   17'h1FFFF, 31'h7FFFFFFF, 1'b1);
        run_op("lsb",   17'h00001, 31'h00000000, 1'b0);
        run_op("zero",  17'h00000, 31'h00000000, 1'b0);
        run_op("f_0f",  17'h0000F, 31'h00000038, 1'b0);
        run_op("f_0ffff", 17'h0FFFF, 31'h3FFF8000, 1'b0);

        // Backpressure: result frozen for 10 cycles, a stray request is ignored.
        sif.f         = 17'h16000;
        sif.in_valid  = 1'b1;
        sif.out_ready = 1'b0;
        tick();
        sif.in_valid = 1'b0;
        n = 0;
        while (!sif.out_valid && n < 40) begin
            tick();
            n++;
        end
        check("bp_lat", 64'(n), 64'd17);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                sif.f        = 17'h04000;
                sif.in_valid = 1'b1;
            end else begin
                sif.in_valid = 1'b0;
            end
            tick();
            check("bp_hold", 64'({sif.out_valid, sif.in_ready, sif.ovf, sif.e}),
                  64'({1'b1, 1'b0, 1'b0, 31'h79000000}));
        end
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        tick();
        check("bp_release", 64'({sif.in_ready, sif.out_valid}), 64'b10);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sif.out_valid || !sif.in_ready) n++;
        end
        check("bp_no_extra", 64'(n), 64'd0);

        // Reset at CALC iteration 8 discards the operation and clears e.
        sif.f        = 17'h16000;
        sif.in_valid = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("mid_busy", 64'(sif.in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst", 64'({sif.in_ready, sif.out_valid, sif.ovf, sif.e}),
              64'({1'b1, 1'b0, 1'b0, 31'h0}));
        run_op("after_rst", 17'h02000, 31'h01000000, 1'b0);

        // Back-to-back with in_valid held high.
        sif.f         = 17'h02000;
        sif.in_valid  = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        sif.f    = 17'h04000;
        t_first  = -1;
        t_second = -1;
        e_first  = '0;
        e_second = '0;
        for (int c = 1; c <= 45 && t_second < 0; c++) begin
            if (sif.out_valid) begin
                if (t_first < 0) begin
                    t_first = c - 1;
                    e_first = sif.e;
                end else begin
                    t_second = c - 1;
                    e_second = sif.e;
                end
            end
            tick();
        end
        sif.in_valid = 1'b0;
        check("b2b_t_first", 64'(t_first), 64'd17);
        check("b2b_gap", 64'(t_second - t_first), 64'd19);
        check("b2b_e_first", 64'(e_first), 64'h01000000);
        check("b2b_e_second", 64'(e_second), 64'h04000000);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("final_idle", 64'({sif.in_ready, sif.out_valid}), 64'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
